// File: rtl/btn_pkg.sv
// Shared button-handling definitions: classifier state encodings and the
// default prescaler width also used by the switch debouncer.
package btn_pkg;

    localparam int unsigned BTN_TICK_BITS = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSED   = 2'b01,
        LONG_HELD = 2'b10
    } btn_state_e;

endpackage

// File: rtl/btn_press_classifier_tick_prescaler.sv
// Free-running mod-2^N counter with synchronous clear and count enable;
// tick marks the terminal count while enabled. Shared with the debouncer.
module tick_prescaler #(
    parameter int unsigned N = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_q + N'(1);
        end
    end

    assign tick = en & (r_q == '1);

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies debounced button activity into one-shot press/release/short/long
// events. Define REPEAT_EN to add auto-repeat pulses while held long.
// i_reset is asynchronous and active-low.
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int unsigned TICK_BITS    = BTN_TICK_BITS,
    parameter int unsigned LONG_TICKS   = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned REPEAT_TICKS = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_db,
    output logic             o_press,
    output logic             o_release,
    output logic             o_short_press,
    output logic             o_long_press,
    output logic             o_repeat,
    output logic             o_held,
    output logic [CNT_W-1:0] o_hold_cnt
);

    if (LONG_TICKS == 0 || LONG_TICKS >= (2 ** CNT_W) || REPEAT_TICKS == 0) begin : g_bad_param
        $error("btn_press_classifier: illegal LONG_TICKS/REPEAT_TICKS");
    end

    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic             r_db_q;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;

    logic w_rise;
    logic w_fall;
    logic w_tick;
    logic w_long_hit;
    logic w_rep_hit;
    logic w_press;
    logic w_release;
    logic w_short;
    logic w_long;
    logic w_repeat;

    assign w_rise     = i_db & ~r_db_q;
    assign w_fall     = ~i_db & r_db_q;
    assign w_long_hit = w_tick && (r_hold_cnt == CNT_W'(LONG_TICKS - 1));

    tick_prescaler #(
        .N (TICK_BITS)
    ) u_prescaler (
        .clk   (i_clk),
        .reset (i_reset),
        .en    (r_state != IDLE),
        .clr   (w_rise),
        .tick  (w_tick)
    );

`ifdef REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    logic [REP_W-1:0] r_rep;

    assign w_rep_hit = w_tick && (r_rep == REP_W'(REPEAT_TICKS - 1));

    // Repeat tick counter, held at zero outside LONG_HELD so it restarts on entry.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rep <= '0;
        end else if (r_state != LONG_HELD) begin
            r_rep <= '0;
        end else if (w_tick) begin
            r_rep <= w_rep_hit ? '0 : r_rep + REP_W'(1);
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    // Next state and event pulses; a fall always beats a same-edge tick.
    always_comb begin
        w_state_nxt = r_state;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_press     = 1'b1;
                end
            end
            PRESSED: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                    w_short     = 1'b1;
                end else if (w_long_hit) begin
                    w_state_nxt = LONG_HELD;
                    w_long      = 1'b1;
                end
            end
            LONG_HELD: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else begin
                    w_repeat = w_rep_hit;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_db_q     <= 1'b0;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_db_q    <= i_db;
            r_press   <= w_press;
            r_release <= w_release;
            r_short   <= w_short;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= (w_state_nxt != IDLE);
            // Hold count survives release and restarts only on the next press.
            if (w_press) begin
                r_hold_cnt <= '0;
            end else if (w_tick && (r_hold_cnt != '1)) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press       = r_press;
    assign o_release     = r_release;
    assign o_short_press = r_short;
    assign o_long_press  = r_long;
    assign o_repeat      = r_repeat;
    assign o_held        = r_held;
    assign o_hold_cnt    = r_hold_cnt;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier at TICK_BITS=2 (T=4), LONG_TICKS=8,
// REPEAT_TICKS=4; repeat expectations follow the REPEAT_EN build option.
module tb_btn_press_classifier;

    localparam int unsigned T       = 4;
    localparam int unsigned LONG_T  = 8;
    localparam int unsigned REP_T   = 4;
    localparam int unsigned CNT_W   = 8;

    logic             clk;
    logic             reset;
    logic             db;
    logic             press;
    logic             release_o;
    logic             short_press;
    logic             long_press;
    logic             repeat_o;
    logic             held;
    logic [CNT_W-1:0] hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    btn_press_classifier #(
        .TICK_BITS    (2),
        .LONG_TICKS   (LONG_T),
        .CNT_W        (CNT_W),
        .REPEAT_TICKS (REP_T)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_db          (db),
        .o_press       (press),
        .o_release     (release_o),
        .o_short_press (short_press),
        .o_long_press  (long_press),
        .o_repeat      (repeat_o),
        .o_held        (held),
        .o_hold_cnt    (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {press, release, short, long, repeat, held, hold_cnt}
    function automatic logic [31:0] outs();
        return 32'({press, release_o, short_press, long_press, repeat_o, held, hold_cnt});
    endfunction

    function automatic logic [31:0] pack(input bit p, input bit r, input bit s, input bit l,
                                         input bit rp, input bit h, input int hc);
        logic [CNT_W-1:0] c;
        c = (hc > 255) ? 8'd255 : CNT_W'(hc);
        return 32'({p, r, s, l, rp, h, c});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press at edge 0, release sampled at edge fall_e; checks every edge through fall_e+2.
    task automatic run_press(input string name, input int fall_e, input int long_e, input bit short_exp);
        bit rp;
        int hc;
        for (int k = 0; k <= fall_e + 2; k++) begin
            db = (k < fall_e);
            step();
            hc = ((k <= fall_e) ? k : fall_e) / T;
            rp = 1'b0;
`ifdef REPEAT_EN
            if (long_e >= 0 && k > long_e && k < fall_e && ((k - long_e) % (REP_T * T)) == 0)
                rp = 1'b1;
`endif
            check_eq($sformatf("%s_e%0d", name, k), outs(),
                     pack(k == 0, k == fall_e, short_exp && (k == fall_e),
                          k == long_e, rp, k < fall_e, hc));
        end
    endtask

    initial begin
        reset = 1'b0;
        db    = 1'b1;
        #1;
        check_eq("reset_init", outs(), 32'd0);
        step();
        step();
        check_eq("reset_hold", outs(), 32'd0);
        db = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("idle_after_reset", outs(), 32'd0);

        run_press("short12", 12, -1, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check_eq("idle_keeps_cnt", outs(), pack(0, 0, 0, 0, 0, 0, 3));

        run_press("long40", 40, LONG_T * T, 1'b0);
        run_press("tie32", LONG_T * T, -1, 1'b1);
        run_press("rep70", 70, LONG_T * T, 1'b0);

        // Reset while held: press at edge 0, pull reset low mid-cycle after edge 20.
        db = 1'b1;
        for (int k = 0; k <= 20; k++) step();
        check_eq("pre_reset_held", outs(), pack(0, 0, 0, 0, 0, 1, 5));
        #2 reset = 1'b0;
        #1;
        check_eq("async_reset_clear", outs(), 32'd0);
        step();
        step();
        check_eq("reset_low_db_high", outs(), 32'd0);
        #2 reset = 1'b1;
        run_press("after_reset", 12, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
